// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding two byte requesters into one UART sender.
// Tracks the sender handshake, flags start timeouts and counts completed frames per requester.
module tx_arbiter #(
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic             grant_id,
  output logic             arb_busy,
  output logic             err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int unsigned TMR_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e             state_q;
  logic [7:0]         tx_data_q;
  logic               grant_id_q;
  logic               last_grant_q;
  logic               tx_start_q;
  logic               arb_busy_q;
  logic               err_q;
  logic [TMR_W-1:0]   timer_q;
  logic [CNT_W-1:0]   cnt0_q;
  logic [CNT_W-1:0]   cnt1_q;

  logic               pick_any_s;
  logic               pick_id_s;
  logic               timeout_s;

  // Arbitration decision; the handshake is only offered from IDLE so ready never overlaps arb_busy.
  always_comb begin
    pick_any_s = 1'b0;
    pick_id_s  = 1'b0;
    if ((state_q == IDLE) && en && rst_n) begin
      if (req0_valid && req1_valid) begin
        pick_any_s = 1'b1;
        pick_id_s  = ~last_grant_q;
      end else if (req0_valid) begin
        pick_any_s = 1'b1;
        pick_id_s  = 1'b0;
      end else if (req1_valid) begin
        pick_any_s = 1'b1;
        pick_id_s  = 1'b1;
      end else begin
        pick_any_s = 1'b0;
        pick_id_s  = 1'b0;
      end
    end else begin
      pick_any_s = 1'b0;
      pick_id_s  = 1'b0;
    end
  end

  // timer_q holds the number of cycles elapsed since the START cycle.
  assign timeout_s = (timer_q >= TMR_W'(START_TIMEOUT - 1));

  // Arbiter FSM with registered outputs and frame counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_data_q    <= 8'h00;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      tx_start_q   <= 1'b0;
      arb_busy_q   <= 1'b0;
      err_q        <= 1'b0;
      timer_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any_s) begin
            tx_data_q    <= pick_id_s ? req1_data : req0_data;
            grant_id_q   <= pick_id_s;
            last_grant_q <= pick_id_s;
            tx_start_q   <= 1'b1;
            arb_busy_q   <= 1'b1;
            timer_q      <= '0;
            state_q      <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        START: begin
          tx_start_q <= 1'b0;
          timer_q    <= TMR_W'(1);
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            if (tx_done) begin
              // Sender finished within the same cycle it reported busy.
              if (grant_id_q) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
              end else begin
                cnt0_q <= cnt0_q + CNT_W'(1);
              end
              arb_busy_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              state_q <= WAIT_DONE;
            end
          end else if (timeout_s) begin
            err_q      <= 1'b1;
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (grant_id_q) begin
              cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
              cnt0_q <= cnt0_q + CNT_W'(1);
            end
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            state_q <= WAIT_DONE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          arb_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = pick_any_s & ~pick_id_s;
  assign req1_ready = pick_any_s &  pick_id_s;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign arb_busy   = arb_busy_q;
  assign err        = err_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed scenarios for tx_arbiter; expected grants are queued when requests are driven
// and compared when the arbiter issues tx_start.
module tb_tx_arbiter;

  localparam int unsigned ST    = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             tx_done;
  logic             grant_id;
  logic             arb_busy;
  logic             err;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data_q[$];
  logic       exp_id_q[$];

  tx_arbiter #(.START_TIMEOUT(ST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .arb_busy(arb_busy), .err(err), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    tx_busy = 1'b0; tx_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Plays the sender for one frame: waits for tx_start, checks it against the scoreboard.
  task automatic do_frame(input int busy_dly, input int done_dly);
    logic [7:0] ed;
    logic       eid;
    bit         seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || exp_data_q.size() == 0) begin
      errors++;
      $display("FAIL frame_start: tx_start seen %0d, expected entries %0d", seen, exp_data_q.size());
      return;
    end
    ed  = exp_data_q.pop_front();
    eid = exp_id_q.pop_front();
    checks++;
    if (tx_data !== ed || grant_id !== eid) begin
      errors++;
      $display("FAIL frame_grant: tx_data %h id %0d, expected %h id %0d", tx_data, grant_id, ed, eid);
    end
    tick();
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: tx_start %0d after one cycle, expected 0", tx_start);
    end
    repeat (busy_dly - 1) tick();
    tx_busy = 1'b1;
    repeat (done_dly) tick();
    checks++;
    if (tx_data !== ed || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_hold: tx_data %h arb_busy %0d, expected %h 1", tx_data, arb_busy, ed);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_busy = 1'b0;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: arb_busy %0d, expected 0", arb_busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({tx_start, tx_data, grant_id, arb_busy, err, req0_ready, req1_ready} !== 13'h0 ||
        cnt0 !== 8'h00 || cnt1 !== 8'h00) begin
      errors++;
      $display("FAIL %s: start %0d data %h id %0d busy %0d err %0d rdy %0d%0d cnt %h/%h, expected all 0",
               name, tx_start, tx_data, grant_id, arb_busy, err, req0_ready, req1_ready, cnt0, cnt1);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outputs("reset_values");
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h41;
    exp_data_q.push_back(8'h41); exp_id_q.push_back(1'b0);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: ready %0d%0d, expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    do_frame(2, 10);
    checks++;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd0 || grant_id !== 1'b0 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL single_result: cnt0 %0d cnt1 %0d id %0d data %h, expected 1 0 0 41",
               cnt0, cnt1, grant_id, tx_data);
    end
  endtask

  task automatic test_contention();
    logic ids[4];
    ids[0] = 1'b0; ids[1] = 1'b1; ids[2] = 1'b0; ids[3] = 1'b1;
    apply_reset();
    req0_data = 8'h11; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      exp_id_q.push_back(ids[i]);
      exp_data_q.push_back(ids[i] ? 8'h22 : 8'h11);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_frame(2, 3);
      if (i < 3) begin
        #1;
        checks++;
        if (req0_ready !== ~ids[i+1] || req1_ready !== ids[i+1]) begin
          errors++;
          $display("FAIL rr_ready: after frame %0d ready %0d%0d, expected id %0d", i, req0_ready, req1_ready, ids[i+1]);
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL contention_cnt: cnt0 %0d cnt1 %0d, expected 2 2", cnt0, cnt1);
    end
  endtask

  task automatic test_timeout();
    logic [CNT_W-1:0] c0, c1;
    int found;
    c0 = cnt0; c1 = cnt1;
    found = -1;
    req0_valid = 1'b1; req0_data = 8'h5A;
    tick();
    req0_valid = 1'b0;
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: tx_start %0d, expected 1", tx_start);
    end
    for (int k = 1; k <= int'(ST) + 4; k++) begin
      tick();
      if (err === 1'b1) begin
        found = k;
        break;
      end
    end
    checks++;
    if (found != int'(ST)) begin
      errors++;
      $display("FAIL timeout_delay: err after %0d cycles, expected %0d", found, ST);
    end
    checks++;
    if (arb_busy !== 1'b0 || cnt0 !== c0 || cnt1 !== c1) begin
      errors++;
      $display("FAIL timeout_state: busy %0d cnt %h/%h, expected 0 %h/%h", arb_busy, cnt0, cnt1, c0, c1);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err %0d one cycle later, expected 0", err);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    en = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h33; req1_data = 8'h44;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || arb_busy !== 1'b0 || tx_start !== 1'b0) begin
        errors++;
        $display("FAIL en_low_idle: ready %0d%0d busy %0d start %0d, expected all 0",
                 req0_ready, req1_ready, arb_busy, tx_start);
      end
    end
    en = 1'b1;
    exp_data_q.push_back(8'h33); exp_id_q.push_back(1'b0);
    tick();
    en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    do_frame(3, 4);
    checks++;
    if (cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL en_drop_frame: cnt0 %0d, expected 1", cnt0);
    end
    req1_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if (arb_busy !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL en_low_hold: busy %0d ready1 %0d, expected 0 0", arb_busy, req1_ready);
    end
    req1_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    req1_valid = 1'b1; req1_data = 8'h77;
    tick();
    req1_valid = 1'b0;
    repeat (2) tick();
    tx_busy = 1'b1;
    repeat (3) tick();
    checks++;
    if (arb_busy !== 1'b1 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL midframe_setup: busy %0d data %h, expected 1 77", arb_busy, tx_data);
    end
    rst_n = 1'b0;
    tx_done = 1'b1;
    tick();
    check_reset_outputs("reset_midframe");
    rst_n = 1'b1;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    tick();
    check_reset_outputs("reset_midframe_after");
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_last_grant: ready %0d%0d, expected 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    req1_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      req1_data = 8'(i);
      exp_data_q.push_back(8'(i)); exp_id_q.push_back(1'b1);
      do_frame(1, 0);
      if (i == 254) begin
        checks++;
        if (cnt1 !== 8'hFF) begin
          errors++;
          $display("FAIL wrap_ff: cnt1 %h, expected ff", cnt1);
        end
      end
    end
    req1_valid = 1'b0;
    checks++;
    if (cnt1 !== 8'h00 || cnt0 !== 8'h00) begin
      errors++;
      $display("FAIL wrap_zero: cnt1 %h cnt0 %h, expected 00 00", cnt1, cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_enable();
    test_reset_midframe();
    test_wrap();
    checks++;
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d expected frames never started", exp_data_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
